// File: rtl/jtag_debug_sys_pio_poller.sv
// jtag_debug_sys_pio_poller
//
// Avalon-MM read master that owns every read of the jtag_debug_sys input PIO
// (registered readdata, one-cycle read latency). A free-running poll timer
// periodically samples the PIO data register (address 0) and raises a change
// event whenever the sample differs from the previous one. A single host
// requester shares the slave and wins arbitration over polling.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   poll_en      enables the poll timer (counter held at 0 when low)
//   avm_address  PIO slave address, non-zero only while a read is issued
//   avm_read     PIO read strobe, one cycle per transaction
//   avm_readdata PIO read data, valid the cycle after avm_read
//   req_valid    host read request
//   req_addr     host read address
//   req_ready    host request accepted (high while idle)
//   rsp_valid    one-cycle host response strobe
//   rsp_data     host response data
//   chg_valid    change event pending
//   chg_data     newest changed sample
//   chg_overrun  an unconsumed event was overwritten
//   chg_ready    consumer accepts the change event
module jtag_debug_sys_pio_poller #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned POLL_DIV = 1000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              poll_en,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              req_valid,
  input  logic [1:0]        req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              chg_valid,
  output logic [DATA_W-1:0] chg_data,
  output logic              chg_overrun,
  input  logic              chg_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(POLL_DIV - 1);

  state_e            state_q;
  logic              owner_host_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              poll_pend_q;
  logic [DATA_W-1:0] last_val_q;
  logic              last_valid_q;

  logic tick;
  logic chg_hs;
  logic poll_hit;

  assign req_ready = (state_q == StIdle);
  assign tick      = poll_en && (cnt_q == CntMax);
  assign chg_hs    = chg_valid && chg_ready;

  // A poll sample raises an event when it is the first one since reset or differs
  // from the last recorded sample.
  assign poll_hit  = (state_q == StCapture) && !owner_host_q &&
                     (!last_valid_q || (avm_readdata != last_val_q));

  // Poll timer: counts 0..POLL_DIV-1 while enabled, held at 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!poll_en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Transaction FSM with registered bus, response and change-event outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_host_q <= 1'b0;
      poll_pend_q  <= 1'b0;
      last_val_q   <= '0;
      last_valid_q <= 1'b0;
      avm_read     <= 1'b0;
      avm_address  <= 2'd0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      chg_valid    <= 1'b0;
      chg_data     <= '0;
      chg_overrun  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            owner_host_q <= 1'b1;
            avm_read     <= 1'b1;
            avm_address  <= req_addr;
            state_q      <= StIssue;
          end else if (poll_pend_q) begin
            owner_host_q <= 1'b0;
            poll_pend_q  <= 1'b0;
            avm_read     <= 1'b1;
            avm_address  <= 2'd0;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          avm_read    <= 1'b0;
          avm_address <= 2'd0;
          state_q     <= StCapture;
        end
        StCapture: begin
          if (owner_host_q) begin
            rsp_valid <= 1'b1;
            rsp_data  <= avm_readdata;
          end else if (poll_hit) begin
            last_val_q   <= avm_readdata;
            last_valid_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: begin
          avm_read    <= 1'b0;
          avm_address <= 2'd0;
          state_q     <= StIdle;
        end
      endcase

      // Placed after the serve-clear so a tick on the same edge is not lost; a tick
      // while already pending is simply absorbed.
      if (tick) begin
        poll_pend_q <= 1'b1;
      end

      // A new event on the handshake edge replaces the consumed one, so overrun only
      // flags an event that was pending and not taken on this edge.
      if (poll_hit) begin
        chg_valid   <= 1'b1;
        chg_data    <= avm_readdata;
        chg_overrun <= chg_valid && !chg_ready;
      end else if (chg_hs) begin
        chg_valid   <= 1'b0;
        chg_overrun <= 1'b0;
      end
    end
  end

endmodule
